// File: rtl/esm_instr_window.sv
// Instruction window in front of the ESM core: each accepted fetch beat goes into the
// lowest free slot and is announced. Issue requests read out a slot and free it.
module esm_instr_window #(
  parameter int Instr_word_size = 32,
  parameter int bs              = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [Instr_word_size-1:0] fetch_instr,
  input  logic                       fetch_alusrc,
  input  logic                       fetch_regwrite,
  output logic                       alloc_valid,
  output logic [$clog2(bs)-1:0]      alloc_index,
  output logic [Instr_word_size-1:0] alloc_instr,
  output logic                       alloc_alusrc,
  output logic                       alloc_regwrite,
  input  logic                       issue_en,
  input  logic [$clog2(bs)-1:0]      issue_index,
  output logic                       dispatch_valid,
  output logic [$clog2(bs)-1:0]      dispatch_index,
  output logic [Instr_word_size-1:0] dispatch_instr,
  output logic                       dispatch_alusrc,
  output logic                       dispatch_regwrite,
  output logic [bs-1:0]              slot_valid,
  output logic [$clog2(bs):0]        count,
  output logic                       full,
  output logic                       empty,
  output logic                       issue_err
);

  localparam int bs_bits = $clog2(bs);
  typedef logic [bs_bits:0] cnt_t;
  localparam cnt_t FULL_CNT = cnt_t'(bs);

  logic [bs-1:0]              slot_valid_q, slot_valid_d;
  cnt_t                       count_q, count_d;
  logic [Instr_word_size-1:0] instr_q [bs];
  logic [bs-1:0]              alusrc_q, regwrite_q;

  logic                       alloc_valid_q, alloc_valid_d;
  logic [bs_bits-1:0]         alloc_index_q, alloc_index_d;
  logic [Instr_word_size-1:0] alloc_instr_q, alloc_instr_d;
  logic                       alloc_alusrc_q, alloc_alusrc_d;
  logic                       alloc_regwrite_q, alloc_regwrite_d;
  logic                       dispatch_valid_q, dispatch_valid_d;
  logic [bs_bits-1:0]         dispatch_index_q, dispatch_index_d;
  logic [Instr_word_size-1:0] dispatch_instr_q, dispatch_instr_d;
  logic                       dispatch_alusrc_q, dispatch_alusrc_d;
  logic                       dispatch_regwrite_q, dispatch_regwrite_d;
  logic                       issue_err_q, issue_err_d;

  logic                       full_s, accept_s, issue_hit_s, issue_miss_s, found_s;
  logic [bs_bits-1:0]         free_idx_s;
  logic [bs-1:0]              alloc_mask_s, issue_mask_s;

  // Lowest free slot taken from the registered bitmap only, so a slot freed this cycle is not reused
  always_comb begin
    free_idx_s = '0;
    found_s    = 1'b0;
    for (int k = 0; k < bs; k++) begin
      if (!slot_valid_q[k] && !found_s) begin
        free_idx_s = bs_bits'(k);
        found_s    = 1'b1;
      end else begin
        free_idx_s = free_idx_s;
        found_s    = found_s;
      end
    end
  end

  assign full_s       = (count_q == FULL_CNT);
  assign accept_s     = fetch_valid & ~full_s & ~flush;
  assign issue_hit_s  = issue_en & slot_valid_q[issue_index] & ~flush;
  assign issue_miss_s = issue_en & ~slot_valid_q[issue_index] & ~flush;
  assign alloc_mask_s = accept_s ? ({{(bs-1){1'b0}}, 1'b1} << free_idx_s) : '0;
  assign issue_mask_s = issue_hit_s ? ({{(bs-1){1'b0}}, 1'b1} << issue_index) : '0;

  // Occupancy bitmap and count next state
  always_comb begin
    slot_valid_d = slot_valid_q;
    count_d      = count_q;
    if (flush) begin
      slot_valid_d = '0;
      count_d      = '0;
    end else begin
      slot_valid_d = (slot_valid_q & ~issue_mask_s) | alloc_mask_s;
      case ({accept_s, issue_hit_s})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Announcement, dispatch and error pulses; payload fields hold while their valid is low
  always_comb begin
    alloc_valid_d       = accept_s;
    alloc_index_d       = alloc_index_q;
    alloc_instr_d       = alloc_instr_q;
    alloc_alusrc_d      = alloc_alusrc_q;
    alloc_regwrite_d    = alloc_regwrite_q;
    dispatch_valid_d    = issue_hit_s;
    dispatch_index_d    = dispatch_index_q;
    dispatch_instr_d    = dispatch_instr_q;
    dispatch_alusrc_d   = dispatch_alusrc_q;
    dispatch_regwrite_d = dispatch_regwrite_q;
    issue_err_d         = issue_miss_s;
    if (accept_s) begin
      alloc_index_d    = free_idx_s;
      alloc_instr_d    = fetch_instr;
      alloc_alusrc_d   = fetch_alusrc;
      alloc_regwrite_d = fetch_regwrite;
    end else begin
      alloc_index_d    = alloc_index_q;
    end
    if (issue_hit_s) begin
      dispatch_index_d    = issue_index;
      dispatch_instr_d    = instr_q[issue_index];
      dispatch_alusrc_d   = alusrc_q[issue_index];
      dispatch_regwrite_d = regwrite_q[issue_index];
    end else begin
      dispatch_index_d    = dispatch_index_q;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid_q        <= '0;
      count_q             <= '0;
      alloc_valid_q       <= 1'b0;
      alloc_index_q       <= '0;
      alloc_instr_q       <= '0;
      alloc_alusrc_q      <= 1'b0;
      alloc_regwrite_q    <= 1'b0;
      dispatch_valid_q    <= 1'b0;
      dispatch_index_q    <= '0;
      dispatch_instr_q    <= '0;
      dispatch_alusrc_q   <= 1'b0;
      dispatch_regwrite_q <= 1'b0;
      issue_err_q         <= 1'b0;
    end else begin
      slot_valid_q        <= slot_valid_d;
      count_q             <= count_d;
      alloc_valid_q       <= alloc_valid_d;
      alloc_index_q       <= alloc_index_d;
      alloc_instr_q       <= alloc_instr_d;
      alloc_alusrc_q      <= alloc_alusrc_d;
      alloc_regwrite_q    <= alloc_regwrite_d;
      dispatch_valid_q    <= dispatch_valid_d;
      dispatch_index_q    <= dispatch_index_d;
      dispatch_instr_q    <= dispatch_instr_d;
      dispatch_alusrc_q   <= dispatch_alusrc_d;
      dispatch_regwrite_q <= dispatch_regwrite_d;
      issue_err_q         <= issue_err_d;
    end
  end

  // Slot payload storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < bs; k++) begin
        instr_q[k] <= '0;
      end
      alusrc_q   <= '0;
      regwrite_q <= '0;
    end else if (accept_s) begin
      instr_q[free_idx_s]    <= fetch_instr;
      alusrc_q[free_idx_s]   <= fetch_alusrc;
      regwrite_q[free_idx_s] <= fetch_regwrite;
    end
  end

  assign fetch_ready       = ~full_s;
  assign full              = full_s;
  assign empty             = (count_q == '0);
  assign slot_valid        = slot_valid_q;
  assign count             = count_q;
  assign alloc_valid       = alloc_valid_q;
  assign alloc_index       = alloc_index_q;
  assign alloc_instr       = alloc_instr_q;
  assign alloc_alusrc      = alloc_alusrc_q;
  assign alloc_regwrite    = alloc_regwrite_q;
  assign dispatch_valid    = dispatch_valid_q;
  assign dispatch_index    = dispatch_index_q;
  assign dispatch_instr    = dispatch_instr_q;
  assign dispatch_alusrc   = dispatch_alusrc_q;
  assign dispatch_regwrite = dispatch_regwrite_q;
  assign issue_err         = issue_err_q;

endmodule

// File: tb/tb_esm_instr_window.sv
// Scoreboard bench for esm_instr_window: a behavioural window model pushes the expected
// pulses for every driven cycle; they are popped and compared one cycle later.
module tb_esm_instr_window;
  localparam int W  = 32;
  localparam int BS = 16;
  localparam int BB = 4;

  logic          clk, rst, flush, fetch_valid, fetch_ready, fetch_alusrc, fetch_regwrite;
  logic [W-1:0]  fetch_instr;
  logic          alloc_valid, alloc_alusrc, alloc_regwrite;
  logic [BB-1:0] alloc_index;
  logic [W-1:0]  alloc_instr;
  logic          issue_en;
  logic [BB-1:0] issue_index;
  logic          dispatch_valid, dispatch_alusrc, dispatch_regwrite;
  logic [BB-1:0] dispatch_index;
  logic [W-1:0]  dispatch_instr;
  logic [BS-1:0] slot_valid;
  logic [BB:0]   count;
  logic          full, empty, issue_err;

  esm_instr_window #(.Instr_word_size(W), .bs(BS)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_instr(fetch_instr),
    .fetch_alusrc(fetch_alusrc), .fetch_regwrite(fetch_regwrite),
    .alloc_valid(alloc_valid), .alloc_index(alloc_index), .alloc_instr(alloc_instr),
    .alloc_alusrc(alloc_alusrc), .alloc_regwrite(alloc_regwrite),
    .issue_en(issue_en), .issue_index(issue_index),
    .dispatch_valid(dispatch_valid), .dispatch_index(dispatch_index),
    .dispatch_instr(dispatch_instr), .dispatch_alusrc(dispatch_alusrc),
    .dispatch_regwrite(dispatch_regwrite),
    .slot_valid(slot_valid), .count(count), .full(full), .empty(empty),
    .issue_err(issue_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic av; logic [BB-1:0] ai; logic [W-1:0] ains; logic aa; logic ar;
    logic dv; logic [BB-1:0] di; logic [W-1:0] dins; logic da; logic dr;
    logic err;
  } exp_t;

  exp_t          sb[$];
  logic [BS-1:0] m_valid;
  logic [W-1:0]  m_instr [BS];
  logic [BS-1:0] m_alusrc, m_regwrite;
  int            m_count;
  int            checks = 0;
  int            errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: model the edge from current inputs, push expectation, then pop and compare.
  task automatic cycle();
    exp_t e, g;
    logic is_full, acc, iss, err;
    int   idx;
    is_full = (m_count == BS);
    check_eq("fetch_ready", fetch_ready, !is_full);
    idx = 0;
    for (int k = BS - 1; k >= 0; k--) if (!m_valid[k]) idx = k;
    acc = fetch_valid && !is_full && !flush;
    iss = issue_en && m_valid[issue_index] && !flush;
    err = issue_en && !m_valid[issue_index] && !flush;
    e.av = acc; e.ai = idx[BB-1:0]; e.ains = fetch_instr; e.aa = fetch_alusrc; e.ar = fetch_regwrite;
    e.dv = iss; e.di = issue_index; e.dins = m_instr[issue_index];
    e.da = m_alusrc[issue_index]; e.dr = m_regwrite[issue_index];
    e.err = err;
    sb.push_back(e);
    if (flush) begin
      m_valid = '0;
      m_count = 0;
    end else begin
      if (iss) begin
        m_valid[issue_index] = 1'b0;
        m_count--;
      end
      if (acc) begin
        m_valid[idx]    = 1'b1;
        m_instr[idx]    = fetch_instr;
        m_alusrc[idx]   = fetch_alusrc;
        m_regwrite[idx] = fetch_regwrite;
        m_count++;
      end
    end
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check_eq("alloc_valid", alloc_valid, g.av);
    if (g.av) begin
      check_eq("alloc_index", alloc_index, g.ai);
      check_eq("alloc_instr", alloc_instr, g.ains);
      check_eq("alloc_ctl", {alloc_alusrc, alloc_regwrite}, {g.aa, g.ar});
    end
    check_eq("dispatch_valid", dispatch_valid, g.dv);
    if (g.dv) begin
      check_eq("dispatch_index", dispatch_index, g.di);
      check_eq("dispatch_instr", dispatch_instr, g.dins);
      check_eq("dispatch_ctl", {dispatch_alusrc, dispatch_regwrite}, {g.da, g.dr});
    end
    check_eq("issue_err", issue_err, g.err);
    check_eq("slot_valid", slot_valid, m_valid);
    check_eq("count", count, m_count);
    check_eq("popcount", count, $countones(slot_valid));
    check_eq("full", full, m_count == BS);
    check_eq("empty", empty, m_count == 0);
  endtask

  task automatic drv(input logic fv, input logic ie, input logic [BB-1:0] ii, input logic fl);
    fetch_valid    = fv;
    issue_en       = ie;
    issue_index    = ii;
    flush          = fl;
    fetch_instr    = $urandom;
    fetch_alusrc   = 1'($urandom_range(0, 1));
    fetch_regwrite = 1'($urandom_range(0, 1));
    cycle();
  endtask

  task automatic model_clear();
    m_valid = '0; m_alusrc = '0; m_regwrite = '0; m_count = 0;
    for (int k = 0; k < BS; k++) m_instr[k] = '0;
    sb.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_slot_valid"}, slot_valid, 16'h0000);
    check_eq({tag, "_count"}, count, 5'd0);
    check_eq({tag, "_empty_full"}, {empty, full}, 2'b10);
    check_eq({tag, "_pulses"}, {alloc_valid, dispatch_valid, issue_err}, 3'b000);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; fetch_valid = 1'b0; issue_en = 1'b0; issue_index = '0;
    fetch_instr = '0; fetch_alusrc = 1'b0; fetch_regwrite = 1'b0;
    model_clear();
    #12;
    check_reset_state("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // T2: fill, then one refused beat
    for (int i = 0; i < BS; i++) begin
      drv(1'b1, 1'b0, 4'd0, 1'b0);
      check_eq("t2_idx", alloc_index, i);
    end
    check_eq("t2_full", {full, fetch_ready}, 2'b10);
    drv(1'b1, 1'b0, 4'd0, 1'b0);
    check_eq("t2_refused", alloc_valid, 1'b0);

    // T3: issue slot 5 from a full window, next accept reuses it
    drv(1'b0, 1'b1, 4'd5, 1'b0);
    check_eq("t3_disp_idx", dispatch_index, 4'd5);
    check_eq("t3_count", count, 5'd15);
    drv(1'b1, 1'b0, 4'd0, 1'b0);
    check_eq("t3_realloc", alloc_index, 4'd5);

    // T4: simultaneous accept and issue
    drv(1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) drv(1'b1, 1'b0, 4'd0, 1'b0);
    drv(1'b1, 1'b1, 4'd1, 1'b0);
    check_eq("t4_alloc_idx", alloc_index, 4'd4);
    check_eq("t4_count", count, 5'd4);
    check_eq("t4_bitmap", slot_valid, 16'h001D);

    // T5: issue to an empty slot
    drv(1'b0, 1'b1, 4'd9, 1'b0);
    check_eq("t5_err", {issue_err, dispatch_valid}, 2'b10);
    drv(1'b0, 1'b0, 4'd0, 1'b0);
    check_eq("t5_err_pulse", issue_err, 1'b0);

    // T6: flush overrides accept and issue
    drv(1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 7; i++) drv(1'b1, 1'b0, 4'd0, 1'b0);
    drv(1'b1, 1'b1, 4'd2, 1'b1);
    check_eq("t6_flush", {count, alloc_valid, dispatch_valid}, {5'd0, 2'b00});

    // Mixed random traffic
    for (int i = 0; i < 400; i++) begin
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          4'($urandom_range(0, BS - 1)), $urandom_range(0, 60) == 0);
    end

    // T1: asynchronous reset in the middle of traffic
    fetch_valid = 1'b1; issue_en = 1'b1; issue_index = 4'd0;
    rst = 1'b0;
    #1;
    check_reset_state("t1_async");
    model_clear();
    @(posedge clk);
    #1;
    check_reset_state("t1_held");
    fetch_valid = 1'b0; issue_en = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    drv(1'b1, 1'b0, 4'd0, 1'b0);
    check_eq("t1_after", alloc_index, 4'd0);
    drv(1'b0, 1'b1, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
